// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Serial transmitter that drains bytes from a show-ahead FIFO and sends each
// one as an 8N1 frame (or 8E1 when PARITY_EN=1): start bit, eight data bits
// LSB first, optional even-parity bit, stop bit. Every bit lasts
// CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   PARITY_EN     1 inserts an even-parity bit after the data bits
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset; aborts any frame in flight
//   empty    in   upstream FIFO empty flag
//   rdata    in   upstream FIFO head byte, valid whenever empty=0
//   rinc     out  FIFO pop request (combinational)
//   txd      out  serial line, idle high (registered)
//   busy     out  high while a frame is in progress (registered)
//   tx_done  out  one-cycle pulse on the last cycle of each frame (registered)
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] rdata,
    output logic       rinc,
    output logic       txd,
    output logic       busy,
    output logic       tx_done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       data_reg, data_next;
    logic             txd_reg, txd_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             bit_end;

    assign bit_end = (cnt_reg == CNT_LAST);

    // Popping only from IDLE guarantees at most one pop per frame, and the
    // reset term keeps the FIFO untouched while the block is being reset.
    assign rinc = (state_reg == S_IDLE) && !empty && !rst;

    assign txd     = txd_reg;
    assign busy    = busy_reg;
    assign tx_done = done_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
        // The latched byte is meaningless outside a frame, so it needs no reset.
        data_reg <= data_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;

        case (state_reg)
            S_IDLE: begin
                if (rinc) begin
                    state_next = S_START;
                    cnt_next   = '0;
                    idx_next   = '0;
                    data_next  = rdata;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx_reg == 3'd7) begin
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        txd_next  = 1'b1;
        busy_next = (state_next != S_IDLE);
        done_next = (state_next == S_STOP) && (cnt_next == CNT_LAST);

        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = data_next[idx_next];
            S_PARITY: txd_next = ^data_next;       // even parity
            default:  txd_next = 1'b1;
        endcase
    end

endmodule
